// File: rtl/gprs_wb_pkg.sv
// Shared types and helpers for the GPR file write-back front end.
package gprs_wb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned NREG_DEF   = 1 << ADDR_W_DEF;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] ws;
        logic [DATA_W_DEF-1:0] wd;
    } wb_entry_t;

    function automatic logic [NREG_DEF-1:0] onehot_reg(input logic [ADDR_W_DEF-1:0] addr);
        logic [NREG_DEF-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/gprs_wb_fifo.sv
// In-order circular buffer with two ordered push ports (push0 older) and one pop.
// Entries and valid bits are presented in age order: index 0 is the head.
module gprs_wb_fifo
    import gprs_wb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0,
    input  wb_entry_t        push0_entry,
    input  logic             push1,
    input  wb_entry_t        push1_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [DEPTH-1:0] valid,
    output wb_entry_t        entries [DEPTH]
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr1;

    // push1 lands behind push0 when both fire, otherwise at the write pointer
    assign wr_ptr1 = wr_ptr + PTR_W'(push0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= push0_entry;
        if (push1) mem[wr_ptr1] <= push1_entry;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = mem[rd_ptr + PTR_W'(k)];
            valid[k]   = CNT_W'(k) < count;
        end
    end

endmodule

// File: rtl/gprs_writeback.sv
// Write-side front end of the 8x16 GPR file: merges load and ALU results into an
// in-order queue and drains one write per cycle. Optional macro: GPRS_WB_FWD_EN.
module gprs_writeback
    import gprs_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_ws,
    input  logic [DATA_W-1:0] ld_wd,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_ws,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              we,
    output logic [ADDR_W-1:0] ws,
    output logic [DATA_W-1:0] wd,
    output logic [NREG-1:0]   pending,
    output logic              full,
    output logic              empty
`ifdef GPRS_WB_FWD_EN
   ,input  logic [ADDR_W-1:0] fwd_rs1,
    input  logic [ADDR_W-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic [DEPTH-1:0] valid;
    wb_entry_t        entries [DEPTH];
    logic             ld_push;
    logic             alu_push;
    logic             pop;

    // Readiness from the registered count only; load owns the last free slot
    assign free      = CNT_W'(DEPTH) - count;
    assign ld_ready  = free >= CNT_W'(1);
    assign alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !ld_valid);
    assign ld_push   = ld_valid && ld_ready;
    assign alu_push  = alu_valid && alu_ready;
    assign pop       = count != '0;

    gprs_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0       (ld_push),
        .push0_entry (wb_entry_t'{ws: ld_ws, wd: ld_wd}),
        .push1       (alu_push),
        .push1_entry (wb_entry_t'{ws: alu_ws, wd: alu_wd}),
        .pop         (pop),
        .count       (count),
        .valid       (valid),
        .entries     (entries)
    );

    // Output register feeding the register file write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we <= 1'b0;
            ws <= '0;
            wd <= '0;
        end else begin
            we <= pop;
            if (pop) begin
                ws <= entries[0].ws;
                wd <= entries[0].wd;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (we) pending = onehot_reg(ws);
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k]) pending = pending | onehot_reg(entries[k].ws);
        end
    end

    assign full  = count == CNT_W'(DEPTH);
    assign empty = (count == '0) && !we;

`ifdef GPRS_WB_FWD_EN
    // Later matches override earlier ones, so the youngest writer supplies the data
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [ADDR_W-1:0] rs,
        input logic              out_we,
        input logic [ADDR_W-1:0] out_ws,
        input logic [DATA_W-1:0] out_wd,
        input logic [DEPTH-1:0]  vld,
        input wb_entry_t         ent [DEPTH]
    );
        logic [DATA_W:0] r;
        r = '0;
        if (out_we && out_ws == rs) r = {1'b1, out_wd};
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && ent[k].ws == rs) r = {1'b1, ent[k].wd};
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(fwd_rs1, we, ws, wd, valid, entries);
        {fwd_hit2, fwd_data2} = fwd_lookup(fwd_rs2, we, ws, wd, valid, entries);
    end
`endif

endmodule

// File: tb/tb_gprs_writeback.sv
// Directed self-checking bench for gprs_writeback with a register-file model and write log.
module tb_gprs_writeback;

    logic        clk;
    logic        reset;
    logic        ld_valid, alu_valid;
    logic        ld_ready, alu_ready;
    logic [2:0]  ld_ws, alu_ws;
    logic [15:0] ld_wd, alu_wd;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [7:0]  pending;
    logic        full, empty;
`ifdef GPRS_WB_FWD_EN
    logic [2:0]  fwd_rs1, fwd_rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gprs_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_ws     (ld_ws),
        .ld_wd     (ld_wd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_ws    (alu_ws),
        .alu_wd    (alu_wd),
        .we        (we),
        .ws        (ws),
        .wd        (wd),
        .pending   (pending),
        .full      (full),
        .empty     (empty)
`ifdef GPRS_WB_FWD_EN
       ,.fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model plus a log of every write it captures
    logic [15:0] rf [8];
    logic [2:0]  log_ws  [64];
    logic [15:0] log_wd  [64];
    int          log_cyc [64];
    int          log_n = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we) begin
            if (log_n < 64) begin
                log_ws[log_n]  = ws;
                log_wd[log_n]  = wd;
                log_cyc[log_n] = cyc;
            end
            log_n = log_n + 1;
            rf[ws] <= wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    int base;

    initial begin
        reset = 1'b1;
        ld_valid = 1'b0; alu_valid = 1'b0;
        ld_ws = '0; ld_wd = '0; alu_ws = '0; alu_wd = '0;
`ifdef GPRS_WB_FWD_EN
        fwd_rs1 = '0; fwd_rs2 = '0;
`endif
        repeat (2) tick;
        check("rst_we", we, 0);
        check("rst_ws", ws, 0);
        check("rst_wd", wd, 0);
        check("rst_pending", pending, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        reset = 1'b0;
        tick;
        check("post_rst_we", we, 0);

        // Single ALU write
        alu_valid = 1; alu_ws = 3'd5; alu_wd = 16'h1234;
        #1 check("single_alu_ready", alu_ready, 1);
        tick;
        alu_valid = 0;
        check("single_t_we", we, 0);
        check("single_t_pending", pending, 8'h20);
        check("single_t_empty", empty, 0);
        tick;
        check("single_we", we, 1);
        check("single_ws", ws, 5);
        check("single_wd", wd, 16'h1234);
        check("single_pending", pending, 8'h20);
        tick;
        check("single_done_we", we, 0);
        check("single_done_pending", pending, 0);
        check("single_done_empty", empty, 1);
        check("single_rf5", rf[5], 16'h1234);

        // Both producers in one cycle, same destination
        base = log_n;
        ld_valid = 1; ld_ws = 3'd2; ld_wd = 16'hAAAA;
        alu_valid = 1; alu_ws = 3'd2; alu_wd = 16'hBBBB;
        #1;
        check("dual_ld_ready", ld_ready, 1);
        check("dual_alu_ready", alu_ready, 1);
        tick;
        ld_valid = 0; alu_valid = 0;
        check("dual_pending", pending, 8'h04);
        tick;
        check("dual_w0_we", we, 1);
        check("dual_w0_ws", ws, 2);
        check("dual_w0_wd", wd, 16'hAAAA);
        tick;
        check("dual_w1_we", we, 1);
        check("dual_w1_wd", wd, 16'hBBBB);
        tick;
        check("dual_end_we", we, 0);
        check("dual_rf2", rf[2], 16'hBBBB);
        check("dual_nwrites", log_n - base, 2);

        // Last-slot arbitration with three entries queued
        base = log_n;
        ld_valid = 1; ld_ws = 3'd1; ld_wd = 16'h0101;
        alu_valid = 1; alu_ws = 3'd2; alu_wd = 16'h0202;
        tick;
        ld_ws = 3'd3; ld_wd = 16'h0303;
        alu_ws = 3'd4; alu_wd = 16'h0404;
        #1 check("slot_free2_alu_ready", alu_ready, 1);
        tick;
        check("slot_pending", pending, 8'h1E);
        check("slot_full", full, 0);
        ld_ws = 3'd5; ld_wd = 16'h0505;
        alu_ws = 3'd6; alu_wd = 16'h0606;
        #1;
        check("slot_ld_ready", ld_ready, 1);
        check("slot_alu_ready", alu_ready, 0);
        tick;
        ld_valid = 0;
        #1 check("slot_alu_ready_late", alu_ready, 1);
        tick;
        alu_valid = 0;
        repeat (6) tick;
        check("slot_nwrites", log_n - base, 6);
        for (int i = 0; i < 6; i++) begin
            check("slot_order_ws", log_ws[base + i], i + 1);
            check("slot_order_wd", log_wd[base + i], 16'h0101 * (i + 1));
        end
        check("slot_rf6", rf[6], 16'h0606);
        check("slot_empty", empty, 1);

        // Stream of ten ALU writes across pointer wrap
        base = log_n;
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1; alu_ws = 3'(i % 8); alu_wd = 16'(i);
            #1 check("wrap_ready", alu_ready, 1);
            tick;
        end
        alu_valid = 0;
        repeat (4) tick;
        check("wrap_nwrites", log_n - base, 10);
        for (int i = 0; i < 10; i++) begin
            check("wrap_ws", log_ws[base + i], i % 8);
            check("wrap_wd", log_wd[base + i], i);
            check("wrap_cycle", log_cyc[base + i] - log_cyc[base], i);
        end

        // Reset while draining
        ld_valid = 1; ld_ws = 3'd7; ld_wd = 16'h7777;
        alu_valid = 1; alu_ws = 3'd6; alu_wd = 16'h6666;
        tick;
        ld_ws = 3'd5; ld_wd = 16'h5555;
        alu_ws = 3'd4; alu_wd = 16'h4444;
        tick;
        ld_valid = 0; alu_valid = 0;
        check("rmid_pre_we", we, 1);
        check("rmid_pre_pending", pending, 8'hF0);
        base = log_n;
        reset = 1;
        #1;
        check("rmid_we", we, 0);
        check("rmid_pending", pending, 0);
        check("rmid_empty", empty, 1);
        tick;
        reset = 0;
        repeat (3) tick;
        check("rmid_nwrites", log_n - base, 0);
        check("rmid_after_empty", empty, 1);

`ifdef GPRS_WB_FWD_EN
        // Forwarding picks the youngest writer
        fwd_rs1 = 3'd3; fwd_rs2 = 3'd4;
        ld_valid = 1; ld_ws = 3'd3; ld_wd = 16'h0011;
        alu_valid = 1; alu_ws = 3'd3; alu_wd = 16'h0022;
        tick;
        ld_valid = 0; alu_valid = 0;
        check("fwd_q_hit1", fwd_hit1, 1);
        check("fwd_q_data1", fwd_data1, 16'h0022);
        check("fwd_q_hit2", fwd_hit2, 0);
        tick;
        check("fwd_mix_hit1", fwd_hit1, 1);
        check("fwd_mix_data1", fwd_data1, 16'h0022);
        tick;
        check("fwd_out_hit1", fwd_hit1, 1);
        check("fwd_out_data1", fwd_data1, 16'h0022);
        tick;
        check("fwd_gone_hit1", fwd_hit1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gprs_writeback.md
Name: gprs_writeback

Overview:
- Write-side front end for the 8x16 general-purpose register file.
- Collects results from two producers, the ALU result path and the load-return path, each with a valid/ready handshake.
- Buffers results in a small in-order queue and drains them at one write per cycle onto the register file's we/ws/wd port.
- Exports a per-register pending mask so decode can stall on outstanding writes.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width.
- NREG, 8, number of registers (2**ADDR_W).
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  load result valid
- ld_ready  out  1  load result accepted this cycle when ld_valid is also high
- ld_ws  in  ADDR_W  load destination register
- ld_wd  in  DATA_W  load data
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- alu_ws  in  ADDR_W  ALU destination register
- alu_wd  in  DATA_W  ALU data
- we  out  1  register file write enable (registered)
- ws  out  ADDR_W  register file write address (registered)
- wd  out  DATA_W  register file write data (registered)
- pending  out  NREG  bit r set while any write to register r is queued or being presented on we/ws/wd
- full  out  1  queue count == DEPTH
- empty  out  1  queue count == 0 and we == 0
- fwd_rs1, fwd_rs2  in  ADDR_W  forwarding lookup addresses (only with GPRS_WB_FWD_EN)
- fwd_hit1, fwd_hit2  out  1  lookup hit (only with GPRS_WB_FWD_EN)
- fwd_data1, fwd_data2  out  DATA_W  forwarded data (only with GPRS_WB_FWD_EN)

Behaviour:
- Reset (async, active-high):
  - queue flushed, count=0.
  - we=0, ws=0, wd=0, pending=0, full=0, empty=1.
  - In-flight results are discarded; no write to the register file while reset is high or on the first edge after release.
- Readiness uses the registered count only; there is no same-cycle credit for a pop. Let free = DEPTH-count.
  - ld_ready = (free>=1).
  - alu_ready = (free>=2) or (free>=1 and !ld_valid). Load has priority for the last slot.
- Enqueue on clock edge t:
  - If both producers handshake, the load entry is enqueued first (older), then the ALU entry.
  - Count increments by 0, 1 or 2.
- Drain: on each edge where count>0 (before this edge's enqueue), the head is popped into the output register: we<=1, ws<=head.ws, wd<=head.wd. Otherwise we<=0, and ws/wd hold their values.
- Latency: a result handshaken at edge t drives we=1 after edge t+1 when the queue was empty, and the register file captures it at edge t+2. Throughput is 1 write per cycle.
- Count update per edge: count <= count + pushes - pop. Full and empty may overlap with push/pop in the same cycle without loss.
- Read and write pointers wrap modulo DEPTH.
- Ordering is strictly FIFO. Multiple queued writes to the same register are all performed in order, so the last one wins in the register file.
- No special treatment of register 0.
- pending is combinational from registers: OR over valid queue entries and the output register (when we=1) of one-hot(ws).
- Producers must hold valid/ws/wd stable until ready. Data is sampled only on a handshake.

Optional Feature:
- Macro GPRS_WB_FWD_EN.
- When defined, the fwd_* ports exist. For each lookup, fwd_hit is set if the output register (we=1) or any valid queue entry targets that address. fwd_data is taken from the youngest matching entry: queue entries are younger than the output register, and the newest queue entry is youngest. Lookup is combinational, with zero latency.
- When undefined, the fwd_* ports and the match logic are absent. Decode must stall on pending.

Decomposition:
- Package gprs_wb_pkg holds:
  - typedef wb_entry_t as a packed struct {ws, wd}.
  - Default width constants DATA_W_DEF=16, ADDR_W_DEF=3.
  - A function onehot_reg(addr) returning an NREG-bit mask.
- Sub-module gprs_wb_fifo: circular buffer with 2 ordered push ports and 1 pop port. It exposes count, the valid-entry vector and the raw entries for the pending and forwarding logic.

Test Plan:
- Reset mid-drain: queue 3 entries, assert reset for 1 cycle -> we=0 immediately, pending=0, empty=1; no regfile write of the flushed entries.
- Single ALU write: alu_ws=5, alu_wd=0x1234 at edge t, queue empty -> we=1, ws=5, wd=0x1234 after edge t+1; pending[5]=1 from after t until we drops.
- Simultaneous producers: ld (2, 0xAAAA) and alu (2, 0xBBBB) in the same cycle with empty queue -> both ready; two consecutive writes, 0xAAAA then 0xBBBB; regfile r2 ends 0xBBBB.
- Last-slot arbitration: count=3 (DEPTH=4), both valid -> ld_ready=1, alu_ready=0; ALU accepted on a later cycle, no data lost, full asserts at count 4.
- Pointer wrap: stream 10 ALU writes to registers 0..7,0,1 with data = index -> 10 in-order writes with matching ws/wd, one per cycle at steady state.
- GPRS_WB_FWD_EN: queue (3,0x0011) then (3,0x0022), fwd_rs1=3, fwd_rs2=4 -> fwd_hit1=1, fwd_data1=0x0022, fwd_hit2=0.
